// File: rtl/psum_accumulator_if.sv
// Stream bundle for psum_accumulator: PSUM input beats in, requantized activation out.
// slave is the accumulator's view; master is the PE/consumer side.
interface psum_accumulator_if #(
    parameter int ACC_W = 18
);
    logic             in_valid;
    logic             in_ready;
    logic [13:0]      psum_in;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [ACC_W:0]   out_acc;

    modport master (
        output in_valid, psum_in, out_ready,
        input  in_ready, out_valid, out_data, out_acc
    );

    modport slave (
        input  in_valid, psum_in, out_ready,
        output in_ready, out_valid, out_data, out_acc
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates unsigned CIM partial sums over a group of tiles, adds a signed bias,
// then ReLU/signed-clamps and shift-requantizes to a 4-bit activation behind valid/ready.
module psum_accumulator #(
    parameter int MAX_TILES = 16,
    parameter int ACC_W     = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [4:0]           cfg_tiles,
    input  logic [11:0]          cfg_bias,
    input  logic [3:0]           cfg_shift,
    input  logic                 cfg_relu,
    psum_accumulator_if.slave    bus,
    output logic [4:0]           tile_cnt
);

    if (14 + $clog2(MAX_TILES) > ACC_W) begin : g_acc_w_check
        $error("psum_accumulator: ACC_W too narrow for MAX_TILES");
    end
    if (MAX_TILES < 1 || MAX_TILES > 31) begin : g_tiles_check
        $error("psum_accumulator: MAX_TILES must fit the 5-bit tile counter");
    end

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [4:0]             MAX_T5 = 5'(MAX_TILES);
    localparam logic signed [ACC_W:0]  Q_P15  = (ACC_W + 1)'(15);
    localparam logic signed [ACC_W:0]  Q_P7   = (ACC_W + 1)'(7);
    localparam logic signed [ACC_W:0]  Q_N8   = (ACC_W + 1)'(-8);

    state_t                  state_q, state_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [4:0]              tile_cnt_q, tile_cnt_d;
    logic [4:0]              tiles_q, tiles_d;
    logic [11:0]             bias_q, bias_d;
    logic [3:0]              shift_q, shift_d;
    logic                    relu_q, relu_d;
    logic [3:0]              out_data_q, out_data_d;
    logic [ACC_W:0]          out_acc_q, out_acc_d;

    logic                    first_beat;
    logic                    last_beat;
    logic [4:0]              use_tiles;
    logic [4:0]              n_tiles;
    logic [11:0]             use_bias;
    logic [3:0]              use_shift;
    logic                    use_relu;
    logic [ACC_W-1:0]        acc_sum;
    logic signed [ACC_W:0]   sum_s;
    logic signed [ACC_W:0]   q_s;
    logic [3:0]              q_clamped;

    // The first beat of a group must already see the live config, so it is
    // muxed in here rather than waiting for the latch to take effect.
    always_comb begin
        first_beat = (tile_cnt_q == '0);
        use_tiles  = first_beat ? cfg_tiles : tiles_q;
        use_bias   = first_beat ? cfg_bias  : bias_q;
        use_shift  = first_beat ? cfg_shift : shift_q;
        use_relu   = first_beat ? cfg_relu  : relu_q;

        if (use_tiles == '0) begin
            n_tiles = 5'd1;
        end else if (use_tiles > MAX_T5) begin
            n_tiles = MAX_T5;
        end else begin
            n_tiles = use_tiles;
        end
        last_beat = (tile_cnt_q == (n_tiles - 5'd1));

        acc_sum = acc_q + {{(ACC_W-14){1'b0}}, bus.psum_in};
        sum_s   = $signed({1'b0, acc_sum})
                + $signed({{(ACC_W-11){use_bias[11]}}, use_bias});
        q_s     = sum_s >>> use_shift;

        if (use_relu) begin
            if (q_s[ACC_W]) begin
                q_clamped = 4'h0;
            end else if (q_s > Q_P15) begin
                q_clamped = 4'hF;
            end else begin
                q_clamped = q_s[3:0];
            end
        end else begin
            if (q_s < Q_N8) begin
                q_clamped = 4'h8;
            end else if (q_s > Q_P7) begin
                q_clamped = 4'h7;
            end else begin
                q_clamped = q_s[3:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tile_cnt_d = tile_cnt_q;
        tiles_d    = tiles_q;
        bias_d     = bias_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        out_data_d = out_data_q;
        out_acc_d  = out_acc_q;

        if (clr) begin
            acc_d      = '0;
            tile_cnt_d = '0;
            state_d    = ST_ACC;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        if (first_beat) begin
                            tiles_d = cfg_tiles;
                            bias_d  = cfg_bias;
                            shift_d = cfg_shift;
                            relu_d  = cfg_relu;
                        end
                        if (last_beat) begin
                            acc_d      = '0;
                            tile_cnt_d = '0;
                            out_acc_d  = sum_s;
                            out_data_d = q_clamped;
                            state_d    = ST_OUT;
                        end else begin
                            acc_d      = acc_sum;
                            tile_cnt_d = tile_cnt_q + 5'd1;
                        end
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACC;
                    end
                end
                default: state_d = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            tile_cnt_q <= '0;
            tiles_q    <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_acc_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tile_cnt_q <= tile_cnt_d;
            tiles_q    <= tiles_d;
            bias_q     <= bias_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
            out_acc_q  <= out_acc_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_acc   = out_acc_q;
    assign tile_cnt      = tile_cnt_q;

endmodule
